// File: rtl/digit_serial_add_sub.sv
// Digit-serial WIDTH-bit add/sub: one 4-bit ripple slice per clock, LSD first.
// Valid/ready on both sides; flags are loaded with the final digit.
module digit_serial_add_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DIGITS-1:0][3:0] a_reg;
  logic [DIGITS-1:0][3:0] b_reg;
  logic [DIGITS-1:0][3:0] res_reg;
  logic [DIGITS-1:0][3:0] res_nx;
  logic                   sub_reg;
  logic                   carry_reg;
  logic [CW-1:0]          cnt;

  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] s_dig;
  logic [4:0] rc;
  logic       accept;
  logic       last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (state == RUN) & (cnt == LAST);
  assign result    = res_reg;

  assign a_dig = a_reg[cnt];
  assign b_dig = b_reg[cnt] ^ {4{sub_reg}};

  always_comb begin
    rc    = '0;
    s_dig = '0;
    rc[0] = carry_reg;
    for (int i = 0; i < 4; i++) begin
      s_dig[i]  = a_dig[i] ^ b_dig[i] ^ rc[i];
      rc[i+1]   = (a_dig[i] & b_dig[i]) |
                  (rc[i] & (a_dig[i] ^ b_dig[i]));
    end
  end

  // zero must see the fresh top digit, not the stale registered one
  always_comb begin
    res_nx      = res_reg;
    res_nx[cnt] = s_dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      sub_reg   <= sub;
      carry_reg <= sub;
      cnt       <= '0;
    end else if (state == RUN) begin
      res_reg   <= res_nx;
      carry_reg <= rc[4];
      cnt       <= cnt + 1'b1;
      if (last) begin
        carry_out <= rc[4];
        overflow  <= (a_dig[3] == b_dig[3]) &
                     (s_dig[3] != a_dig[3]);
        zero      <= (res_nx == '0);
      end
    end
  end

endmodule

// File: doc/digit_serial_add_sub.md
Name: digit_serial_add_sub

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit digit per clock, least significant digit first.
- Each cycle it drives a 4-bit ripple-carry add/sub slice (b XOR sub, carry-in = sub on digit 0) and registers the slice sum and carry for the next digit.
- It is the sequencing stage directly upstream of the 4-bit slice: it feeds the slice operands and consumes its sum and carry.
- Valid/ready handshakes on both sides; it sits between the operand source and the result consumer in the ALU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.
- DIGITS, WIDTH/4, derived number of digit cycles; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/sub valid
- in_ready  output  1  block can accept operands
- sub  input  1  0 = a+b, 1 = a−b
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- carry_out  output  1  final carry; on sub, 1 = no borrow (a ≥ b unsigned)
- overflow  output  1  two's-complement overflow
- zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state = IDLE. Operand registers, result, carry register, digit counter, carry_out, overflow, zero and out_valid all clear to 0. in_ready = 1, since in_ready is decoded as state == IDLE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: capture a, b, sub; carry_reg <= sub; cnt <= 0; go to RUN.
- RUN (in_ready = 0), each cycle k = cnt:
  - Slice inputs: a_reg[4k+3:4k], b_reg[4k+3:4k] XOR {4{sub_reg}}, cin = carry_reg.
  - Register the slice sum into result[4k+3:4k]; carry_reg <= slice carry; cnt <= cnt+1.
  - When cnt == DIGITS−1, also load carry_out, overflow and zero, then go to DONE.
- DONE:
  - out_valid = 1. result and flags hold stable.
  - On out_ready go to IDLE; out_valid drops on the next cycle.
- Latency:
  - Operand accept at edge E0 → out_valid high after edge E_DIGITS (DIGITS cycles; 4 for WIDTH = 16).
  - Minimum issue interval is DIGITS+2 cycles (one IDLE bubble). There is no overlap of operations.
- Flags:
  - overflow = (a_reg[MSB] == b_eff[MSB]) & (sum[MSB] != a_reg[MSB]), with b_eff = b XOR sub.
  - zero = (full WIDTH-bit result == 0), computed using the final digit's fresh sum.
- Boundaries:
  - in_valid while in RUN or DONE is ignored; no capture occurs.
  - out_ready in IDLE or RUN has no effect.
  - result is held until the next acceptance. Lower digits are overwritten progressively during the next RUN, and result is undefined for consumers while out_valid = 0.
  - rst asserted mid-RUN or mid-DONE: immediate return to the reset state. The partial result is discarded and the next operation computes correctly.
- Arithmetic is purely modulo 2^WIDTH. The sub path is a + ~b + 1, with the +1 injected as the digit-0 carry-in.

Test Plan (WIDTH = 16):
- Add 0x1234 + 0x0FFF:
  - result = 0x2233, carry_out = 0, overflow = 0, zero = 0.
  - out_valid rises exactly 4 cycles after the accept edge.
- Sub 0x0005 − 0x0007 → result = 0xFFFE, carry_out = 0 (borrow), overflow = 0, zero = 0.
- Add 0x7FFF + 0x0001 → result = 0x8000, overflow = 1, carry_out = 0. Then sub 0x8000 − 0x0001 → result = 0x7FFF, overflow = 1, carry_out = 1.
- Add 0xFFFF + 0x0001 → result = 0x0000, carry_out = 1, zero = 1, overflow = 0.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid with new operands.
  - Required: result and flags stable, in_ready = 0, new operands not captured.
  - On out_ready = 1, return to IDLE with in_ready = 1 the following cycle.
- Reset mid-operation:
  - Assert rst after 2 digit cycles of 0x1234 + 0x1111.
  - Required: all outputs clear asynchronously (in_ready = 1, out_valid = 0).
  - A following add 0x0001 + 0x0001 yields 0x0002, carry_out = 0.
